// File: rtl/uart_tx_if.sv
// Parallel-side bundle of the UART transmitter: byte request, frame
// configuration, the serial line and the busy flag.
interface uart_tx_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  Data_Valid;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic                  TX_OUT;
  logic                  busy;

  // Producer of bytes: drives the request and configuration, watches the line.
  modport master (
    output P_DATA, Data_Valid, PAR_EN, PAR_TYP,
    input  TX_OUT, busy
  );

  // The transmitter itself.
  modport slave (
    input  P_DATA, Data_Valid, PAR_EN, PAR_TYP,
    output TX_OUT, busy
  );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter. One CLK cycle is one bit period. Frame: start bit,
// DATA_WIDTH data bits LSB-first, optional parity bit, stop bit.
// TX_OUT and busy are registered decodes of the current state, so the line
// trails the state register by one cycle.
module uart_tx #(
  parameter int DATA_WIDTH = 8
) (
  input  logic      CLK,
  input  logic      RST,
  uart_tx_if.slave  bus
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  logic [2:0]            state_q,   state_d;
  logic [CNT_W-1:0]      cnt_q,     cnt_d;
  logic [DATA_WIDTH-1:0] data_q,    data_d;
  logic                  par_en_q,  par_en_d;
  logic                  par_typ_q, par_typ_d;
  logic                  tx_out_q,  tx_out_d;
  logic                  busy_q,    busy_d;

  // Next-state logic; the request and configuration are captured only in IDLE.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    par_en_d  = par_en_q;
    par_typ_d = par_typ_q;
    case (state_q)
      IDLE: begin
        if (bus.Data_Valid) begin
          data_d    = bus.P_DATA;
          par_en_d  = bus.PAR_EN;
          par_typ_d = bus.PAR_TYP;
          state_d   = START;
        end
      end
      START: begin
        cnt_d   = '0;
        state_d = DATA;
      end
      DATA: begin
        if (cnt_q == LAST_BIT) begin
          state_d = par_en_q ? PARITY : STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PARITY: state_d = STOP;
      STOP:   state_d = IDLE;
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Line and busy decode of the current state; unknown encodings look idle.
  always_comb begin
    tx_out_d = 1'b1;
    busy_d   = 1'b0;
    case (state_q)
      START: begin
        tx_out_d = 1'b0;
        busy_d   = 1'b1;
      end
      DATA: begin
        tx_out_d = data_q[cnt_q];
        busy_d   = 1'b1;
      end
      PARITY: begin
        tx_out_d = (^data_q) ^ par_typ_q;
        busy_d   = 1'b1;
      end
      STOP: begin
        tx_out_d = 1'b1;
        busy_d   = 1'b1;
      end
      default: begin
        tx_out_d = 1'b1;
        busy_d   = 1'b0;
      end
    endcase
  end

  // State, latched frame contents and registered outputs; reset abandons any frame.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      data_q    <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      tx_out_q  <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      par_en_q  <= par_en_d;
      par_typ_q <= par_typ_d;
      tx_out_q  <= tx_out_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.TX_OUT = tx_out_q;
  assign bus.busy   = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: table of directed frames with hand-computed line
// sequences, plus hand-written reset, busy-request and back-to-back sequences.
module tb_uart_tx;

  logic CLK = 1'b0;
  logic RST = 1'b0;

  uart_tx_if #(.DATA_WIDTH(8)) bus ();

  uart_tx #(.DATA_WIDTH(8)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        par_en;
    logic        par_typ;
    logic [7:0]  data;
    int          len;
    logic [0:10] seq;      // expected TX_OUT, first bit at index 0
    logic        corrupt;  // change P_DATA/PAR_TYP right after acceptance
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Send one frame described by v and check every bit time plus the idle after it.
  task automatic run_frame(input vec_t v, input int idx);
    logic [7:0] rx;
    bus.P_DATA     = v.data;
    bus.PAR_EN     = v.par_en;
    bus.PAR_TYP    = v.par_typ;
    bus.Data_Valid = 1'b1;
    tick();                                  // edge k: accepted
    bus.Data_Valid = 1'b0;
    if (v.corrupt) begin
      bus.P_DATA  = ~v.data;
      bus.PAR_TYP = ~v.par_typ;
    end
    rx = '0;
    for (int i = 0; i < v.len; i++) begin
      tick();
      check($sformatf("v%0d tx bit%0d", idx, i), {31'd0, bus.TX_OUT}, {31'd0, v.seq[i]});
      check($sformatf("v%0d busy bit%0d", idx, i), {31'd0, bus.busy}, 32'd1);
      if (i >= 1 && i <= 8) rx[i-1] = bus.TX_OUT;
    end
    check($sformatf("v%0d rx byte", idx), {24'd0, rx}, {24'd0, v.data});
    tick();
    check($sformatf("v%0d busy after", idx), {31'd0, bus.busy}, 32'd0);
    check($sformatf("v%0d idle line", idx), {31'd0, bus.TX_OUT}, 32'd1);
    tick();
  endtask

  initial begin
    logic [0:21] b2b_tx;
    logic [0:21] b2b_busy;
    int          waited;

    vecs[0] = '{par_en: 1'b1, par_typ: 1'b1, data: 8'hAA, len: 11, seq: 11'b0_01010101_1_1, corrupt: 1'b0};
    vecs[1] = '{par_en: 1'b1, par_typ: 1'b0, data: 8'h82, len: 11, seq: 11'b0_01000001_0_1, corrupt: 1'b0};
    vecs[2] = '{par_en: 1'b0, par_typ: 1'b0, data: 8'h45, len: 10, seq: 11'b0_10100010_1_0, corrupt: 1'b0};
    vecs[3] = '{par_en: 1'b1, par_typ: 1'b1, data: 8'hFF, len: 11, seq: 11'b0_11111111_1_1, corrupt: 1'b0};
    vecs[4] = '{par_en: 1'b1, par_typ: 1'b0, data: 8'h00, len: 11, seq: 11'b0_00000000_0_1, corrupt: 1'b0};
    vecs[5] = '{par_en: 1'b1, par_typ: 1'b0, data: 8'h82, len: 11, seq: 11'b0_01000001_0_1, corrupt: 1'b1};

    bus.P_DATA     = '0;
    bus.Data_Valid = 1'b0;
    bus.PAR_EN     = 1'b0;
    bus.PAR_TYP    = 1'b0;

    // Reset and idle
    repeat (2) @(posedge CLK);
    #1;
    check("reset tx", {31'd0, bus.TX_OUT}, 32'd1);
    check("reset busy", {31'd0, bus.busy}, 32'd0);
    @(negedge CLK);
    RST = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("idle tx", {31'd0, bus.TX_OUT}, 32'd1);
      check("idle busy", {31'd0, bus.busy}, 32'd0);
    end

    // Table of directed frames
    for (int n = 0; n < 6; n++) run_frame(vecs[n], n);

    // Request while busy is dropped
    bus.P_DATA     = 8'h00;
    bus.PAR_EN     = 1'b0;
    bus.PAR_TYP    = 1'b0;
    bus.Data_Valid = 1'b1;
    tick();
    bus.Data_Valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("drop tx bit%0d", i), {31'd0, bus.TX_OUT}, {31'd0, (i == 9)});
      check($sformatf("drop busy bit%0d", i), {31'd0, bus.busy}, 32'd1);
      if (i == 3) begin
        bus.P_DATA     = 8'hFF;
        bus.Data_Valid = 1'b1;
      end
      if (i == 4) bus.Data_Valid = 1'b0;
    end
    for (int i = 0; i < 12; i++) begin
      tick();
      check("drop no second frame tx", {31'd0, bus.TX_OUT}, 32'd1);
      check("drop no second frame busy", {31'd0, bus.busy}, 32'd0);
    end

    // Data_Valid held high for 25 cycles: frames separated by one idle bit
    b2b_tx   = {10'b0_10100010_1, 1'b1, 10'b0_10100010_1, 1'b1};
    b2b_busy = {{10{1'b1}}, 1'b0, {10{1'b1}}, 1'b0};
    bus.P_DATA     = 8'h45;
    bus.PAR_EN     = 1'b0;
    bus.Data_Valid = 1'b1;
    tick();
    for (int i = 0; i < 22; i++) begin
      tick();
      check($sformatf("b2b tx %0d", i), {31'd0, bus.TX_OUT}, {31'd0, b2b_tx[i]});
      check($sformatf("b2b busy %0d", i), {31'd0, bus.busy}, {31'd0, b2b_busy[i]});
    end
    repeat (2) tick();
    bus.Data_Valid = 1'b0;
    waited = 0;
    while (bus.busy !== 1'b0 && waited < 30) begin
      tick();
      waited++;
    end
    check("b2b drains in time", {31'd0, (waited < 30)}, 32'd1);
    tick();
    check("b2b final idle busy", {31'd0, bus.busy}, 32'd0);
    check("b2b final idle tx", {31'd0, bus.TX_OUT}, 32'd1);

    // Asynchronous reset mid-frame
    bus.P_DATA     = 8'h00;
    bus.PAR_EN     = 1'b1;
    bus.Data_Valid = 1'b1;
    tick();
    bus.Data_Valid = 1'b0;
    repeat (4) tick();
    check("midframe busy before reset", {31'd0, bus.busy}, 32'd1);
    check("midframe tx before reset", {31'd0, bus.TX_OUT}, 32'd0);
    #1;
    RST = 1'b0;
    #1;
    check("async reset tx", {31'd0, bus.TX_OUT}, 32'd1);
    check("async reset busy", {31'd0, bus.busy}, 32'd0);
    @(negedge CLK);
    RST = 1'b1;
    for (int i = 0; i < 14; i++) begin
      tick();
      check("abandoned tx", {31'd0, bus.TX_OUT}, 32'd1);
      check("abandoned busy", {31'd0, bus.busy}, 32'd0);
    end

    // Frame after reset recovery
    run_frame(vecs[2], 6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
UART transmitter that serializes one parallel byte into a standard asynchronous frame on TX_OUT.
- Frame order: start bit, 8 data bits LSB-first, optional parity bit, stop bit.
- Sits directly upstream of the UART receive path on the serial line, in the same configurable-UART subsystem.
- Runs on the UART TX clock, which is pre-divided so that one CLK cycle equals one bit period. No internal oversampling or prescale.

Parameters:
- DATA_WIDTH, 8, width of the parallel data word and number of data bits per frame.

Ports:
- CLK  input  1  TX bit clock; all state updates on the rising edge.
- RST  input  1  asynchronous, active-low reset.
- P_DATA  input  DATA_WIDTH  parallel byte to transmit; sampled only when accepted.
- Data_Valid  input  1  request to send P_DATA; sampled on the rising edge.
- PAR_EN  input  1  1 = insert parity bit; sampled with P_DATA.
- PAR_TYP  input  1  0 = even parity, 1 = odd parity; sampled with P_DATA.
- TX_OUT  output  1  serial line; idles high.
- busy  output  1  high while a frame is on the line.

Behaviour:
- Reset (RST=0, asynchronous, any state):
  - TX_OUT=1, busy=0, FSM=IDLE, bit counter=0.
  - Latched data, parity-enable and parity-type registers cleared.
  - Takes effect immediately, including mid-frame. The partial frame is abandoned, not resumed.
- Outputs are registered: TX_OUT and busy change only on CLK rising edge (or asynchronously on reset).
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - TX_OUT=1, busy=0.
  - If Data_Valid=1 at edge k: latch P_DATA, PAR_EN and PAR_TYP; go to START.
  - Parity is computed from the latched byte, so later P_DATA changes have no effect on the frame.
- START: TX_OUT=0, busy=1, for one cycle. Then go to DATA with counter=0.
- DATA:
  - TX_OUT=latched_data[counter], busy=1; counter increments each cycle.
  - After bit DATA_WIDTH-1: go to PARITY if latched PAR_EN=1, else STOP.
- PARITY: TX_OUT = XOR-reduce(latched_data) XOR latched PAR_TYP, busy=1, for one cycle, then STOP.
- STOP: TX_OUT=1, busy=1, for one cycle, then IDLE.
- Latency:
  - Data_Valid accepted at edge k → TX_OUT=0 and busy=1 visible after edge k+1.
  - Frame length is 11 cycles with parity, 10 without.
  - busy falls after the edge that ends STOP.
- Data_Valid handling while busy=1 (START..STOP): ignored. No queueing; the request is dropped.
- Back-to-back frames: Data_Valid held high continuously is accepted in the first IDLE cycle after STOP. This gives exactly one idle-high cycle between frames.
- Config changes: PAR_EN/PAR_TYP changes during a frame do not affect that frame; they apply at the next acceptance.
- Counter: log2(DATA_WIDTH) bits. It never wraps inside DATA; it is reset to 0 on entry to DATA.
- No illegal-state lockup: unreachable encodings return to IDLE with TX_OUT=1.

Test Plan:
- Reset idle:
  - Stimulus: RST low then high, Data_Valid=0 for 20 cycles.
  - Required: TX_OUT=1 and busy=0 throughout.
  - Required: asserting RST low mid-frame forces TX_OUT=1 and busy=0 without waiting for a clock edge.
- Odd parity frame:
  - Stimulus: PAR_EN=1, PAR_TYP=1, P_DATA=8'hAA, one-cycle Data_Valid.
  - Required TX_OUT sequence: 0, 0,1,0,1,0,1,0,1, 1, 1.
  - Required: busy high for exactly 11 cycles.
  - Loop TX_OUT into uart_rx (Prescale=16 on an oversampled clock); required: P_DATA=8'hAA and data_valid=1.
- Even parity frame:
  - Stimulus: PAR_EN=1, PAR_TYP=0, P_DATA=8'h82.
  - Required TX_OUT sequence: 0, 0,1,0,0,0,0,0,1, 0, 1.
- No parity:
  - Stimulus: PAR_EN=0, P_DATA=8'h45.
  - Required TX_OUT sequence: 0, 1,0,1,0,0,0,1,0, 1.
  - Required: busy high for exactly 10 cycles.
- Request during busy:
  - Stimulus: pulse Data_Valid with P_DATA=8'hFF at cycle 4 of a frame sending 8'h00.
  - Required: the frame continues unchanged and no second frame follows.
  - Stimulus: hold Data_Valid high for 25 cycles.
  - Required: two frames separated by exactly one TX_OUT=1 idle cycle.
- Latching:
  - Stimulus: change P_DATA and PAR_TYP on the cycle after acceptance.
  - Required: the transmitted data and parity bits reflect the originally accepted values.
